// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR wrapper types and constants
//
// Holds the arbiter state encoding, the default read data returned on a
// watchdog abort, and the FIR wrapper register addresses used by masters.
package fir_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY0 = 2'd1,
    ARB_BUSY1 = 2'd2,
    ARB_HOLD1 = 2'd3
  } arb_state_e;

  localparam logic [31:0] FIR_TO_DATA     = 32'hDEAD_BEEF;
  localparam logic [31:0] FIR_ADR_AP_CTRL = 32'h3000_0000;
  localparam logic [31:0] FIR_ADR_STREAM  = 32'h3000_0080;

  // Width of the watchdog counter.
  localparam int FIR_WD_W = 16;

endpackage

// File: rtl/fir_arb_watchdog.sv
// rtl/fir_arb_watchdog.sv - BUSY-cycle counter that flags a slave that never acks
//
// Ports:
//   wb_clk_i  clock
//   wb_rst_i  asynchronous active-high reset
//   busy_i    arbiter is in a BUSY state this cycle
//   expire_o  this BUSY cycle is the TIMEOUT_CYCLES-th one of the transaction
//
// The counter is held at zero outside BUSY, so it is automatically clear on
// the first cycle of every transaction (the arbiter always passes through a
// non-BUSY cycle between transactions).
module fir_arb_watchdog
  import fir_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic busy_i,
  output logic expire_o
);

  localparam logic [FIR_WD_W-1:0] LAST = FIR_WD_W'(TIMEOUT_CYCLES - 1);

  logic [FIR_WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (busy_i) cnt_d = cnt_q + FIR_WD_W'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire_o = busy_i && (cnt_q == LAST);

endmodule

// File: rtl/fir_wb_arbiter.sv
// rtl/fir_wb_arbiter.sv - two-master round-robin Wishbone arbiter for the FIR wrapper
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   mN_valid/we/sel/adr/dat_i     master N request (N = 0 CPU, 1 FIR DMA)
//   mN_ack, mN_dat_o              response routed back to master N
//   m1_lock                       m1 keeps the grant across consecutive transactions
//   s_valid/we/sel/adr/dat_o      request forwarded to the FIR wrapper
//   s_ack, s_dat_i                wrapper response
//   err_o                         sticky watchdog abort flag
//
// Optional feature: define FIR_ARB_TIMEOUT_EN to enable the watchdog that
// aborts a transaction after TIMEOUT_CYCLES BUSY cycles without s_ack.
module fir_wb_arbiter
  import fir_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TO_DATA        = FIR_TO_DATA
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_valid,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack,
  output logic [31:0] m0_dat_o,
  input  logic        m1_valid,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack,
  output logic [31:0] m1_dat_o,
  input  logic        m1_lock,
  output logic        s_valid,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  input  logic        s_ack,
  input  logic [31:0] s_dat_i,
  output logic        err_o
);

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;      // master preferred on the next contended grant
  logic       own_valid;
  logic       wd_expire;
  logic       timeout_hit;

  always_comb begin
    own_valid = 1'b0;
    if (state_q == ARB_BUSY0)      own_valid = m0_valid;
    else if (state_q == ARB_BUSY1) own_valid = m1_valid;
  end

  // A real ack wins over an expiry landing on the same cycle.
  assign timeout_hit = wd_expire & own_valid & ~s_ack;

`ifdef FIR_ARB_TIMEOUT_EN
  logic busy;
  logic err_q, err_d;

  assign busy = (state_q == ARB_BUSY0) || (state_q == ARB_BUSY1);

  fir_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .busy_i  (busy),
    .expire_o(wd_expire)
  );

  assign err_d = err_q | timeout_hit;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign wd_expire      = 1'b0;
  assign err_o          = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_valid && m1_valid) state_d = rr_q ? ARB_BUSY1 : ARB_BUSY0;
        else if (m0_valid)        state_d = ARB_BUSY0;
        else if (m1_valid)        state_d = ARB_BUSY1;
      end
      ARB_BUSY0: begin
        if (s_ack) begin
          state_d = ARB_IDLE;
          rr_d    = 1'b1;
        end else if (!m0_valid) begin
          // Owner withdrew: abort without counting it as its turn.
          state_d = ARB_IDLE;
        end else if (timeout_hit) begin
          state_d = ARB_IDLE;
          rr_d    = 1'b1;
        end
      end
      ARB_BUSY1: begin
        if (s_ack) begin
          state_d = m1_lock ? ARB_HOLD1 : ARB_IDLE;
          rr_d    = 1'b0;
        end else if (!m1_valid) begin
          state_d = ARB_IDLE;
        end else if (timeout_hit) begin
          state_d = ARB_IDLE;
          rr_d    = 1'b0;
        end
      end
      ARB_HOLD1: begin
        if (m1_valid)      state_d = ARB_BUSY1;
        else if (!m1_lock) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_valid  = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_adr    = '0;
    s_dat_o  = '0;
    m0_ack   = 1'b0;
    m0_dat_o = '0;
    m1_ack   = 1'b0;
    m1_dat_o = '0;
    case (state_q)
      ARB_BUSY0: begin
        s_valid  = m0_valid & ~timeout_hit;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_adr    = m0_adr;
        s_dat_o  = m0_dat_i;
        m0_ack   = s_ack | timeout_hit;
        m0_dat_o = timeout_hit ? TO_DATA : s_dat_i;
      end
      ARB_BUSY1: begin
        s_valid  = m1_valid & ~timeout_hit;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_adr    = m1_adr;
        s_dat_o  = m1_dat_i;
        m1_ack   = s_ack | timeout_hit;
        m1_dat_o = timeout_hit ? TO_DATA : s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_wb_arbiter.sv
// tb/tb_fir_wb_arbiter.sv - scoreboard bench for the two-master FIR Wishbone arbiter
module tb_fir_wb_arbiter;
  import fir_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        m0_valid = 1'b0, m0_we = 1'b0;
  logic [3:0]  m0_sel = '0;
  logic [31:0] m0_adr = '0, m0_dat_i = '0;
  logic        m0_ack;
  logic [31:0] m0_dat_o;
  logic        m1_valid = 1'b0, m1_we = 1'b0;
  logic [3:0]  m1_sel = '0;
  logic [31:0] m1_adr = '0, m1_dat_i = '0;
  logic        m1_ack;
  logic [31:0] m1_dat_o;
  logic        m1_lock = 1'b0;
  logic        s_valid, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_o;
  logic        s_ack = 1'b0;
  logic [31:0] s_dat_i = '0;
  logic        err_o;

  fir_wb_arbiter #(
    .TIMEOUT_CYCLES(16),
    .TO_DATA       (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_dat_i(m0_dat_i), .m0_ack(m0_ack), .m0_dat_o(m0_dat_o),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_dat_i(m1_dat_i), .m1_ack(m1_ack), .m1_dat_o(m1_dat_o),
    .m1_lock(m1_lock),
    .s_valid(s_valid), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_ack(s_ack), .s_dat_i(s_dat_i),
    .err_o(err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int   n_checks = 0;
  int   n_errors = 0;
  req_t q0[$], q1[$];     // stimulus not yet presented
  req_t e0[$], e1[$];     // presented, awaiting completion
  int   grant_q[$];       // expected order of completed grants
  bit   m0_done = 0, m1_done = 0;
  bit   slave_en = 1;
  int   slave_lat = 0;
  int   ack0_cnt = 0, ack1_cnt = 0;
  bit   gap_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Master 0: present queued requests one at a time, drop after ack.
  initial begin : drv0
    req_t r;
    forever begin
      @(posedge wb_clk_i); #1;
      if (m0_done) begin
        m0_valid = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_dat_i = '0;
        m0_done = 0;
      end
      if (!m0_valid && !wb_rst_i && q0.size() > 0) begin
        r = q0.pop_front();
        e0.push_back(r);
        m0_valid = 1; m0_we = r.we; m0_sel = 4'hF; m0_adr = r.adr; m0_dat_i = r.dat;
      end
    end
  end

  initial begin : drv1
    req_t r;
    forever begin
      @(posedge wb_clk_i); #1;
      if (m1_done) begin
        m1_valid = 0; m1_we = 0; m1_sel = '0; m1_adr = '0; m1_dat_i = '0;
        m1_done = 0;
      end
      if (!m1_valid && !wb_rst_i && q1.size() > 0) begin
        r = q1.pop_front();
        e1.push_back(r);
        m1_valid = 1; m1_we = r.we; m1_sel = 4'h3; m1_adr = r.adr; m1_dat_i = r.dat;
      end
    end
  end

  // Wrapper model: one-cycle ack pulse slave_lat cycles after s_valid.
  initial begin : slave
    int waitc;
    waitc = 0;
    forever begin
      @(posedge wb_clk_i); #1;
      if (wb_rst_i) begin
        s_ack = 0; waitc = 0;
      end else if (s_ack) begin
        s_ack = 0;
      end else if (s_valid && slave_en) begin
        if (waitc >= slave_lat) begin
          s_ack = 1; s_dat_i = rd_model(s_adr); waitc = 0;
        end else begin
          waitc++;
        end
      end else begin
        waitc = 0;
      end
    end
  end

  // Completion monitor / scoreboard.
  always @(negedge wb_clk_i) begin : mon
    int   owner, expo;
    req_t r;
    if (!wb_rst_i) begin
      if (m0_ack) begin ack0_cnt++; m0_done = 1; end
      if (m1_ack) begin ack1_cnt++; m1_done = 1; end
      if (gap_chk) chk("gap_s_valid", 32'(s_valid), 32'd0);
      gap_chk = s_valid && s_ack;
      if (s_valid && s_ack) begin
        owner = (m0_ack && !m1_ack) ? 0 : ((m1_ack && !m0_ack) ? 1 : 3);
        expo  = 9;
        if (grant_q.size() > 0) expo = grant_q.pop_front();
        chk("grant_owner", 32'(owner), 32'(expo));
        if (owner == 0 && e0.size() > 0) begin
          r = e0.pop_front();
          chk("m0_s_adr", s_adr, r.adr);
          chk("m0_s_we", 32'(s_we), 32'(r.we));
          if (r.we) chk("m0_s_dat", s_dat_o, r.dat);
          chk("m0_rdata", m0_dat_o, rd_model(r.adr));
          chk("m1_dat_idle", m1_dat_o, 32'd0);
        end else if (owner == 1 && e1.size() > 0) begin
          r = e1.pop_front();
          chk("m1_s_adr", s_adr, r.adr);
          chk("m1_s_we", 32'(s_we), 32'(r.we));
          if (r.we) chk("m1_s_dat", s_dat_o, r.dat);
          chk("m1_rdata", m1_dat_o, rd_model(r.adr));
          chk("m0_dat_idle", m0_dat_o, 32'd0);
        end
      end
    end
  end

  task automatic push_req(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    req_t r;
    r.we = we; r.adr = adr; r.dat = dat;
    if (m == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m0_valid || m1_valid || grant_q.size() > 0)
           && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_s_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_s_adr"}, s_adr, 32'd0);
    chk({tag, "_s_bus"}, {27'd0, s_we, s_sel}, 32'd0);
    chk({tag, "_s_dat"}, s_dat_o, 32'd0);
    chk({tag, "_acks"}, {30'd0, m1_ack, m0_ack}, 32'd0);
    chk({tag, "_m_dat"}, m0_dat_o | m1_dat_o, 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin : global_guard
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    int a0, a1, nb;
    req_t r;

    // Reset state.
    repeat (2) @(negedge wb_clk_i);
    chk_outputs_zero("reset");
    wb_rst_i = 0;
    @(negedge wb_clk_i);

    // Simultaneous requests after reset: m0 first, then m1.
    push_req(0, 1'b1, FIR_ADR_AP_CTRL, 32'h0000_0001);
    push_req(1, 1'b0, FIR_ADR_STREAM, 32'h0);
    grant_q.push_back(0); grant_q.push_back(1);
    drain(50);

    // Single m0 write: arbitration latency and routing.
    a0 = ack0_cnt; a1 = ack1_cnt;
    push_req(0, 1'b1, 32'h3000_0010, 32'd64);
    grant_q.push_back(0);
    @(negedge wb_clk_i);
    chk("lat_before", 32'(s_valid), 32'd0);
    @(negedge wb_clk_i);
    chk("lat_s_valid", 32'(s_valid), 32'd1);
    chk("lat_s_adr", s_adr, 32'h3000_0010);
    chk("lat_s_dat", s_dat_o, 32'd64);
    chk("lat_s_sel", 32'(s_sel), 32'hF);
    drain(50);
    chk("single_m0_acks", 32'(ack0_cnt - a0), 32'd1);
    chk("single_m1_acks", 32'(ack1_cnt - a1), 32'd0);

    // Continuous contention: rr now favours m1, strict alternation.
    a0 = ack0_cnt; a1 = ack1_cnt;
    slave_lat = 1;
    for (int i = 0; i < 4; i++) begin
      push_req(0, i[0], 32'h3000_0040 + 32'(4 * i), 32'h100 + 32'(i));
      push_req(1, ~i[0], 32'h3000_0080 + 32'(4 * i), 32'h200 + 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      grant_q.push_back(1); grant_q.push_back(0);
    end
    drain(200);
    chk("alt_m0_acks", 32'(ack0_cnt - a0), 32'd4);
    chk("alt_m1_acks", 32'(ack1_cnt - a1), 32'd4);
    slave_lat = 0;

    // Lock: m1 keeps the bus for write + read, m0 waits until unlock.
    a0 = ack0_cnt;
    m1_lock = 1;
    push_req(1, 1'b1, FIR_ADR_STREAM, 32'h1234_5678);
    push_req(1, 1'b0, FIR_ADR_STREAM, 32'h0);
    grant_q.push_back(1); grant_q.push_back(1); grant_q.push_back(0);
    repeat (2) @(negedge wb_clk_i);
    push_req(0, 1'b0, FIR_ADR_AP_CTRL, 32'h0);
    for (int i = 0; i < 50 && grant_q.size() > 1; i++) @(negedge wb_clk_i);
    chk("lock_m1_done", 32'(grant_q.size()), 32'd1);
    repeat (5) @(negedge wb_clk_i);
    chk("lock_hold_s_valid", 32'(s_valid), 32'd0);
    chk("lock_m0_waiting", 32'(m0_valid), 32'd1);
    chk("lock_m0_no_ack", 32'(ack0_cnt - a0), 32'd0);
    m1_lock = 0;
    drain(50);
    chk("lock_m0_served", 32'(ack0_cnt - a0), 32'd1);

    // Slave that never acks.
    slave_en = 0;
    a0 = ack0_cnt;
    push_req(0, 1'b0, FIR_ADR_AP_CTRL, 32'h0);
`ifdef FIR_ARB_TIMEOUT_EN
    nb = 0;
    for (int i = 0; i < 100 && !m0_ack; i++) begin
      @(negedge wb_clk_i);
      if (s_valid) nb++;
    end
    chk("to_ack", 32'(m0_ack), 32'd1);
    chk("to_busy_cycles", 32'(nb), 32'd15);
    chk("to_data", m0_dat_o, 32'hDEAD_BEEF);
    chk("to_s_valid_drop", 32'(s_valid), 32'd0);
    chk("to_m1_ack", 32'(m1_ack), 32'd0);
    @(negedge wb_clk_i);
    chk("to_err", 32'(err_o), 32'd1);
    if (e0.size() > 0) r = e0.pop_front();
    slave_en = 1;
    push_req(1, 1'b1, FIR_ADR_STREAM, 32'hCAFE_0001);
    grant_q.push_back(1);
    drain(50);
    chk("to_err_sticky", 32'(err_o), 32'd1);
`else
    nb = 0;
    repeat (40) begin
      @(negedge wb_clk_i);
      if (s_valid) nb++;
    end
    chk("wait_no_ack", 32'(ack0_cnt - a0), 32'd0);
    chk("wait_s_valid", 32'(nb), 32'd39);
    chk("wait_err", 32'(err_o), 32'd0);
    grant_q.push_back(0);
    slave_en = 1;
    drain(50);
    chk("wait_done", 32'(ack0_cnt - a0), 32'd1);
    push_req(1, 1'b1, FIR_ADR_STREAM, 32'hCAFE_0001);
    grant_q.push_back(1);
    drain(50);
`endif

    // Reset during BUSY1: outputs drop at once, pending m1 never acked.
    slave_en = 0;
    a1 = ack1_cnt;
    push_req(1, 1'b1, FIR_ADR_STREAM, 32'h5555_AAAA);
    repeat (3) @(negedge wb_clk_i);
    chk("rst_busy1", 32'(s_valid), 32'd1);
    wb_rst_i = 1;
    #1;
    chk_outputs_zero("rst_mid");
    m1_valid = 0; m1_done = 0;
    e1.delete();
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    chk("rst_no_ack", 32'(ack1_cnt - a1), 32'd0);
    slave_en = 1;
    push_req(0, 1'b0, FIR_ADR_AP_CTRL, 32'h0);
    push_req(1, 1'b0, FIR_ADR_STREAM, 32'h0);
    grant_q.push_back(0); grant_q.push_back(1);
    drain(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
